shift_sequencer: RTL



---
 rtl/shift_sequencer.sv | 122 ++++++++++++
 1 files changed

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle shift/rotate of a 16-bit word built around a
// single one-bit shifter stage. The accumulator is fed back through the
// shifter once per cycle for AMT cycles, with a START/BUSY/DONE handshake.
// Also contains the one-bit shifter stage it instantiates.

module shifter (
  input  logic [15:0] D,
  input  logic [1:0]  SEL,
  input  logic        Il,
  input  logic        Ir,
  output logic [15:0] Q
);

  // One-bit move: 00 shl (Il enters LSB), 01 shr (Ir enters MSB), 10 rol, 11 ror
  always_comb begin
    Q = D;
    case (SEL)
      2'b00:   Q = {D[14:0], Il};
      2'b01:   Q = {Ir, D[15:1]};
      2'b10:   Q = {D[14:0], D[15]};
      default: Q = {D[0], D[15:1]};
    endcase
  end

endmodule

module shift_sequencer #(
  parameter int AMT_W = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [15:0]      DIN,
  input  logic [AMT_W-1:0] AMT,
  input  logic [1:0]       MODE,
  input  logic             FILL,
  output logic [15:0]      DOUT,
  output logic             BUSY,
  output logic             DONE
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam logic [AMT_W-1:0] CNT_ONE  = AMT_W'(1);
  localparam logic [AMT_W-1:0] CNT_ZERO = '0;

  state_t           state;
  state_t           state_nxt;
  logic [15:0]      acc;
  logic [15:0]      acc_shf;
  logic [AMT_W-1:0] cnt;
  logic [1:0]       mode_r;
  logic             fill_r;

  // Fill bit drives both ends; the shifter only looks at the one its mode uses
  shifter u_shifter (
    .D   (acc),
    .SEL (mode_r),
    .Il  (fill_r),
    .Ir  (fill_r),
    .Q   (acc_shf)
  );

  // Next-state decode; a zero amount skips SHIFT and goes straight to FINISH
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (START) begin
          state_nxt = (AMT == CNT_ZERO) ? FINISH : SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == CNT_ONE) begin
          state_nxt = FINISH;
        end
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, accumulator and operand latches; operands only load on an accepted START
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      acc    <= '0;
      cnt    <= '0;
      mode_r <= 2'b00;
      fill_r <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (START) begin
            acc    <= DIN;
            cnt    <= AMT;
            mode_r <= MODE;
            fill_r <= FILL;
          end
        end
        SHIFT: begin
          acc <= acc_shf;
          cnt <= cnt - CNT_ONE;
        end
        default: ;
      endcase
    end
  end

  // Outputs come only from registers, so no input reaches an output combinationally
  always_comb begin
    DOUT = acc;
    BUSY = (state == SHIFT) || (state == FINISH);
    DONE = (state == FINISH);
  end

endmodule
